sseg_bcd_counter: RTL and testbench

//  Parametrised multi-digit BCD up/down counter with built-in tick prescaler and

---
 rtl/sseg_bcd_counter.sv | 123 ++++++++++++
 tb/tb_sseg_bcd_counter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sseg_bcd_counter.sv
// Multi-digit BCD up/down counter with a tick prescaler and registered
// seven-segment outputs. Digit 0 is least significant; o_Seg tracks o_Bcd on the same edge.
module sseg_bcd_counter #(
    parameter int NUM_DIGITS     = 2,
    parameter int CLKS_PER_TICK  = 25_000_000,
    parameter bit SATURATE       = 1'b0,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_n,
    input  logic                      i_En,
    input  logic                      i_Up,
    input  logic                      i_Step,
    input  logic                      i_Clear,
    output logic [4*NUM_DIGITS-1:0]   o_Bcd,
    output logic [7*NUM_DIGITS-1:0]   o_Seg,
    output logic                      o_Tick,
    output logic                      o_Wrap
);

    localparam int PW = (CLKS_PER_TICK > 2) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_TICK - 1);

    logic [PW-1:0]                  presc, presc_nxt;
    logic                           tick_int, adv;
    logic [NUM_DIGITS-1:0][3:0]     digits, digits_nxt;
    logic [NUM_DIGITS-1:0][6:0]     seg_q, seg_nxt;
    logic                           wrap_nxt;
    logic                           all_nine, all_zero;

    // Active-high ABCDEFG pattern, inverted for common-anode boards.
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h7E;
            4'd1:    s = 7'h30;
            4'd2:    s = 7'h6D;
            4'd3:    s = 7'h79;
            4'd4:    s = 7'h33;
            4'd5:    s = 7'h5B;
            4'd6:    s = 7'h5F;
            4'd7:    s = 7'h70;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h7B;
            default: s = 7'h00;
        endcase
        return SEG_ACTIVE_LOW ? ~s : s;
    endfunction

    assign tick_int = i_En && (presc == PRESC_MAX);
    assign adv      = tick_int || i_Step;

    always_comb begin
        presc_nxt = presc;
        if (i_Clear)
            presc_nxt = '0;
        else if (i_En)
            presc_nxt = tick_int ? '0 : presc + 1'b1;
    end

    always_comb begin
        all_nine = 1'b1;
        all_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digits[k] != 4'd9) all_nine = 1'b0;
            if (digits[k] != 4'd0) all_zero = 1'b0;
        end
    end

    // Ripple carry/borrow through all digits in one cycle; a full-range
    // ripple naturally produces the wrapped value, saturation just holds.
    always_comb begin
        logic carry;
        logic at_limit;
        digits_nxt = digits;
        wrap_nxt   = 1'b0;
        carry      = 1'b1;
        at_limit   = i_Up ? all_nine : all_zero;
        if (i_Clear) begin
            digits_nxt = '0;
        end else if (adv && !(SATURATE && at_limit)) begin
            wrap_nxt = at_limit;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (carry) begin
                    if (i_Up) begin
                        carry         = (digits[k] == 4'd9);
                        digits_nxt[k] = carry ? 4'd0 : 4'(digits[k] + 4'd1);
                    end else begin
                        carry         = (digits[k] == 4'd0);
                        digits_nxt[k] = carry ? 4'd9 : 4'(digits[k] - 4'd1);
                    end
                end
            end
        end
    end

    always_comb begin
        seg_nxt = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            seg_nxt[k] = enc(digits_nxt[k]);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            presc  <= '0;
            digits <= '0;
            o_Tick <= 1'b0;
            o_Wrap <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++)
                seg_q[k] <= enc(4'd0);
        end else begin
            presc  <= presc_nxt;
            digits <= digits_nxt;
            seg_q  <= seg_nxt;
            o_Tick <= tick_int && !i_Clear;
            o_Wrap <= wrap_nxt;
        end
    end

    assign o_Bcd = digits;
    assign o_Seg = seg_q;

endmodule

// File: tb/tb_sseg_bcd_counter.sv
// Directed bench for sseg_bcd_counter: a wrapping and a saturating instance
// share stimulus; expected values are hand-computed constants.
module tb_sseg_bcd_counter;

    logic        clk = 1'b0;
    logic        rst_n, en, up, step, clr;
    logic [7:0]  bcd_w, bcd_s;
    logic [13:0] seg_w, seg_s;
    logic        tick_w, tick_s, wrap_w, wrap_s;
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    sseg_bcd_counter #(.NUM_DIGITS(2), .CLKS_PER_TICK(4), .SATURATE(1'b0), .SEG_ACTIVE_LOW(1'b1)) u_wrap (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_En(en), .i_Up(up), .i_Step(step), .i_Clear(clr),
        .o_Bcd(bcd_w), .o_Seg(seg_w), .o_Tick(tick_w), .o_Wrap(wrap_w));

    sseg_bcd_counter #(.NUM_DIGITS(2), .CLKS_PER_TICK(4), .SATURATE(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_sat (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_En(en), .i_Up(up), .i_Step(step), .i_Clear(clr),
        .o_Bcd(bcd_s), .o_Seg(seg_s), .o_Tick(tick_s), .o_Wrap(wrap_s));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b1; step = 1'b0; clr = 1'b0;
        cyc(2);
        chk("rst_bcd", bcd_w, 8'h00);
        chk("rst_seg", seg_w, 14'h0081);
        chk("rst_tick", tick_w, 1'b0);
        chk("rst_wrap", wrap_w, 1'b0);

        // 1: tick cadence and count to 10
        rst_n = 1'b1; en = 1'b1;
        cyc(3);
        chk("t1_no_tick", tick_w, 1'b0);
        chk("t1_bcd0", bcd_w, 8'h00);
        cyc(1);
        chk("t1_tick", tick_w, 1'b1);
        chk("t1_bcd1", bcd_w, 8'h01);
        chk("t1_seg1", seg_w, 14'h0080 | 14'h004F);
        cyc(1);
        chk("t1_tick_pulse", tick_w, 1'b0);
        cyc(35);
        chk("t1_bcd10", bcd_w, 8'h10);
        chk("t1_seg10", seg_w, 14'h2781);
        chk("t1_tick10", tick_w, 1'b1);

        // 2: up to 99 then wrap / saturate
        cyc(356);
        chk("t2_bcd99_w", bcd_w, 8'h99);
        chk("t2_bcd99_s", bcd_s, 8'h99);
        cyc(4);
        chk("t2_wrap_bcd", bcd_w, 8'h00);
        chk("t2_wrap_flag", wrap_w, 1'b1);
        chk("t2_sat_bcd", bcd_s, 8'h99);
        chk("t2_sat_noflag", wrap_s, 1'b0);
        cyc(1);
        chk("t2_wrap_pulse", wrap_w, 1'b0);

        // 3: count down from 00 wraps to 99
        up = 1'b0;
        cyc(3);
        chk("t3_down_wrap", bcd_w, 8'h99);
        chk("t3_down_flag", wrap_w, 1'b1);
        chk("t3_sat_down", bcd_s, 8'h98);

        // 4: manual steps with prescaler disabled
        en = 1'b0; clr = 1'b1;
        cyc(1);
        chk("t4_clear", bcd_w, 8'h00);
        clr = 1'b0; up = 1'b1;
        repeat (3) begin
            step = 1'b1; cyc(1);
            step = 1'b0; cyc(1);
            chk("t4_step_notick", tick_w, 1'b0);
        end
        chk("t4_bcd3", bcd_w, 8'h03);
        step = 1'b1;
        cyc(7);
        chk("t4_bcd10", bcd_w, 8'h10);
        up = 1'b0;
        cyc(1);
        chk("t3_borrow", bcd_w, 8'h09);
        chk("t3_borrow_s", bcd_s, 8'h09);
        step = 1'b0; clr = 1'b1;
        cyc(1);
        clr = 1'b0; step = 1'b1;
        cyc(1);
        chk("t3_sat_hold0", bcd_s, 8'h00);
        chk("t3_sat_hold_flag", wrap_s, 1'b0);
        chk("t3_step_wrap", bcd_w, 8'h99);
        chk("t3_step_wrap_flag", wrap_w, 1'b1);

        // step coinciding with a tick advances once
        step = 1'b0; clr = 1'b1;
        cyc(1);
        clr = 1'b0; up = 1'b1; en = 1'b1;
        cyc(3);
        chk("t4_pre_coinc", bcd_w, 8'h00);
        step = 1'b1;
        cyc(1);
        chk("t4_coinc_bcd", bcd_w, 8'h01);
        chk("t4_coinc_tick", tick_w, 1'b1);

        // 5: clear mid-period restarts the prescaler
        en = 1'b0;
        cyc(56);
        chk("t5_bcd57", bcd_w, 8'h57);
        step = 1'b0; en = 1'b1;
        cyc(2);
        clr = 1'b1;
        cyc(1);
        chk("t5_clr_bcd", bcd_w, 8'h00);
        chk("t5_clr_tick", tick_w, 1'b0);
        clr = 1'b0;
        repeat (3) begin
            cyc(1);
            chk("t5_no_early_tick", tick_w, 1'b0);
        end
        cyc(1);
        chk("t5_full_period_tick", tick_w, 1'b1);
        chk("t5_bcd01", bcd_w, 8'h01);
        cyc(3);
        clr = 1'b1;
        cyc(1);
        chk("t5_clr_suppress_tick", tick_w, 1'b0);
        chk("t5_clr_on_tick_bcd", bcd_w, 8'h00);

        // 6: reset beats an advance at 99
        en = 1'b0; clr = 1'b0; up = 1'b0; step = 1'b1;
        cyc(1);
        chk("t6_pre_99", bcd_w, 8'h99);
        up = 1'b1; rst_n = 1'b0;
        cyc(1);
        chk("t6_rst_bcd", bcd_w, 8'h00);
        chk("t6_rst_wrap", wrap_w, 1'b0);
        chk("t6_rst_tick", tick_w, 1'b0);
        chk("t6_rst_seg", seg_w, 14'h0081);
        rst_n = 1'b1; step = 1'b0;
        cyc(1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
